// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on both sides and a WIDTH x WIDTH multiplier.
// Define ALU_SEQ_ITER_MUL_EN to build the multiplier as a one-bit-per-cycle shift-add engine.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic              out_valid_r;
    logic [WIDTH-1:0]  x_r;
    logic [WIDTH-1:0]  y_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              go_mul_s;
    logic              mul_last_s;
    logic [W2-1:0]     res_s;

    // Single-cycle result for every opcode, returned as {y, x}.
    function automatic logic [W2-1:0] alu_compute(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] oa,
        input logic [WIDTH-1:0] ob
    );
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic [WIDTH:0]   sum;
        logic [W2-1:0]    wa;
        logic [W2-1:0]    wb;
        logic [WIDTH+1:0] ob_ext;
        logic [WIDTH+1:0] shift_lim;
        lo        = {WIDTH{1'b0}};
        hi        = {WIDTH{1'b0}};
        sum       = {1'b0, oa} + {1'b0, ob};
        wa        = {{WIDTH{1'b0}}, oa};
        wb        = {{WIDTH{1'b0}}, ob};
        ob_ext    = {2'b00, ob};
        shift_lim = (WIDTH + 2)'(W2);
        case (op)
            4'h0: lo[0] = &oa;
            4'h1: lo[0] = ^oa;
            4'h2: lo[0] = |oa;
            4'h3: lo = oa & ob;
            4'h4: lo = oa | ob;
            4'h5: lo = oa ^ ob;
            4'h6: lo[0] = (oa > ob);
            4'h7: lo[0] = (oa < ob);
            4'h8: lo[0] = (oa == {WIDTH{1'b0}});
            4'h9: lo[0] = (oa == ob);
            4'hA: begin
                lo    = sum[WIDTH-1:0];
                hi[0] = sum[WIDTH];
            end
            4'hB: begin
                lo    = oa - ob;
                hi[0] = (oa < ob);
            end
            4'hC: lo = oa >> ob;
            4'hD: begin
                // Shifting past the 2*WIDTH window must give zero, not a wrapped amount.
                if (ob_ext >= shift_lim) begin
                    {hi, lo} = {W2{1'b0}};
                end else begin
                    {hi, lo} = wa << ob;
                end
            end
            4'hE: {hi, lo} = wa * wb;
            4'hF: lo = ~oa;
            default: lo = {WIDTH{1'b0}};
        endcase
        return {hi, lo};
    endfunction

    // Request acceptance: not while multiplying, and only if the output slot frees up this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_r == MUL) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !out_valid_r || out_ready;
        end
    end

    assign accept_s = in_valid && in_ready_s;
    assign res_s    = alu_compute(opcode, a, b);

`ifdef ALU_SEQ_ITER_MUL_EN
    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    logic [W2-1:0]    acc_r;
    logic [W2-1:0]    mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [5:0]       cnt_r;
    logic [W2-1:0]    acc_next_s;

    assign go_mul_s   = (opcode == 4'hE);
    assign mul_last_s = (cnt_r == CNT_LAST);
    assign busy       = (state_r == MUL);

    // Partial product for the current multiplier bit.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Shift-add engine: operands captured on accept, one multiplier bit retired per MUL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {W2{1'b0}};
            mcand_r  <= {W2{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= 6'd0;
        end else if (accept_s) begin
            acc_r    <= {W2{1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= 6'd0;
        end else if (state_r == MUL) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[W2-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + 6'd1;
        end
    end
`else
    assign go_mul_s   = 1'b0;
    assign mul_last_s = 1'b1;
    assign busy       = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; a same-cycle accept in DONE starts the next operation directly.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s && go_mul_s) begin
                    state_n_s = MUL;
                end else if (accept_s) begin
                    state_n_s = DONE;
                end else if (state_r == DONE && out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = state_r;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = MUL;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Result registers: loaded on single-cycle accept or multiply completion, held under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
        end else if (accept_s && !go_mul_s) begin
            out_valid_r <= 1'b1;
            x_r         <= res_s[WIDTH-1:0];
            y_r         <= res_s[W2-1:WIDTH];
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
`ifdef ALU_SEQ_ITER_MUL_EN
        end else if (state_r == MUL && mul_last_s) begin
            out_valid_r <= 1'b1;
            x_r         <= acc_next_s[WIDTH-1:0];
            y_r         <= acc_next_s[W2-1:WIDTH];
`endif
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign x         = x_r;
    assign y         = y_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8; expectations are hand-computed constants.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;

    int vectors;
    int miscompares;

    alu_seq #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x        (x),
        .y        (y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb);
        in_valid = 1'b1;
        opcode   = op;
        a        = aa;
        b        = bb;
        step();
        in_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic [7:0] ex, input logic [7:0] ey);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_x"}, 32'(x), 32'(ex));
        chk({tag, "_y"}, 32'(y), 32'(ey));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("consumed_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [7:0] aa,
                          input logic [7:0] bb, input logic [7:0] ex, input logic [7:0] ey);
        issue(op, aa, bb);
        result(tag, ex, ey);
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        opcode      = 4'h0;
        a           = 8'h00;
        b           = 8'h00;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xy", {16'h0, y, x}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        single("add_wrap", 4'hA, 8'hFF, 8'h01, 8'h00, 8'h01);
        single("sub_borrow", 4'hB, 8'h03, 8'h05, 8'hFE, 8'h01);
        single("eq", 4'h9, 8'h5A, 8'h5A, 8'h01, 8'h00);
        single("shl4", 4'hD, 8'h81, 8'h04, 8'h10, 8'h08);
        single("shl15", 4'hD, 8'h81, 8'h0F, 8'h00, 8'h80);
        single("shl16", 4'hD, 8'h81, 8'h10, 8'h00, 8'h00);
        single("shr16", 4'hC, 8'h81, 8'h10, 8'h00, 8'h00);
        single("shr3", 4'hC, 8'h81, 8'h03, 8'h10, 8'h00);
        single("andred", 4'h0, 8'hFF, 8'h00, 8'h01, 8'h00);
        single("xorred", 4'h1, 8'h07, 8'h00, 8'h01, 8'h00);
        single("orred", 4'h2, 8'h00, 8'hFF, 8'h00, 8'h00);
        single("and", 4'h3, 8'hF0, 8'h3C, 8'h30, 8'h00);
        single("or", 4'h4, 8'hF0, 8'h0F, 8'hFF, 8'h00);
        single("gt", 4'h6, 8'h05, 8'h03, 8'h01, 8'h00);
        single("lt", 4'h7, 8'h05, 8'h03, 8'h00, 8'h00);
        single("zero", 4'h8, 8'h00, 8'h11, 8'h01, 8'h00);
        single("not", 4'hF, 8'h5A, 8'h00, 8'hA5, 8'h00);
        single("add_nc", 4'hA, 8'h12, 8'h34, 8'h46, 8'h00);

        // Multiply; operands changed after accept must not affect the product.
        issue(4'hE, 8'hFF, 8'hFF);
        a      = 8'h00;
        b      = 8'h00;
        opcode = 4'h0;
`ifdef ALU_SEQ_ITER_MUL_EN
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_not_valid", 32'(out_valid), 32'd0);
            step();
        end
`endif
        result("mul_ffff", 8'h01, 8'hFE);
        chk("mul_busy_done", 32'(busy), 32'd0);
        consume();
        single("mul_small", 4'hE, 8'h0D, 8'h0B, 8'h8F, 8'h00);

        // Back-pressure: held result stays, pending request is not taken.
        issue(4'h5, 8'hAA, 8'hFF);
        in_valid = 1'b1;
        opcode   = 4'h3;
        a        = 8'h0F;
        b        = 8'hFF;
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            result("bp_hold", 8'h55, 8'h00);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_on_consume", 32'(in_ready), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        result("bp_next", 8'h0F, 8'h00);
        consume();

        // Reset in the middle of a multiply (or with its result held).
        issue(4'hE, 8'hFF, 8'hFF);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_xy", {16'h0, y, x}, 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(in_ready), 32'd1);
        step();
        chk("midrst_stays_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
